// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multi-cycle CPU control sequencer
package cpu_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_START  = 3'd5,
    S_ERROR  = 3'd7
  } state_t;
  localparam logic [3:0] OP_ALUR   = 4'd0;
  localparam logic [3:0] OP_CMPR   = 4'd2;
  localparam logic [3:0] OP_SW     = 4'd5;
  localparam logic [3:0] OP_BRANCH = 4'd6;
  localparam logic [3:0] OP_ALUI   = 4'd8;
  localparam logic [3:0] OP_LW     = 4'd9;
  localparam logic [3:0] OP_CMPI   = 4'd10;
  localparam logic [3:0] OP_JAL    = 4'd11;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI, OP_LW, OP_SW, OP_BRANCH, OP_JAL};
  endfunction
endpackage

// File: rtl/ack_timeout_counter.sv
// ack_timeout_counter: counts no-ack cycles of one memory access and flags expiry
module ack_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  logic [7:0] count;
  // clear has priority so a completed access never carries its wait count forward
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + 8'd1;
  assign expired = count == 8'(TIMEOUT);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with shared memory port arbitration
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_load,
  output logic        mdr_load,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halt_err,
  output logic        bus_err,
  output logic [31:0] instr_count
);
  state_t st, nxt;
  logic [3:0] op_q;
  logic mem_phase, expired, retire;
  assign mem_phase = st == S_FETCH || st == S_MEM;
  assign retire = nxt == S_FETCH && (st == S_EXEC || st == S_MEM || st == S_WB);
  assign state = st;
  ack_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!mem_phase || mem_ack),
    .inc     (!mem_ack),
    .expired (expired)
  );
  // next state and Moore strobes; an ack in the expiring cycle still completes the access
  always_comb begin
    nxt = st;
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we = 1'b0;
    ir_load = 1'b0;
    mdr_load = 1'b0;
    pc_load = 1'b0;
    pc_src = PC_PLUS4;
    alu_src = 1'b0;
    reg_write = 1'b0;
    wb_sel = WB_ALU;
    case (st)
      S_START: nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_load = mem_ack;
        nxt = mem_ack ? S_DECODE : expired ? S_ERROR : S_FETCH;
      end
      S_DECODE: nxt = is_legal(opcode) ? S_EXEC : S_ERROR;
      S_EXEC: begin
        alu_src = !(op_q == OP_ALUR || op_q == OP_CMPR);
        if (op_q == OP_BRANCH) begin
          pc_load = br_taken;
          pc_src = PC_BRANCH;
          nxt = S_FETCH;
        end else if (op_q == OP_JAL) begin
          reg_write = 1'b1;
          wb_sel = WB_PC;
          pc_load = 1'b1;
          pc_src = PC_JUMP;
          nxt = S_FETCH;
        end else nxt = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we = op_q == OP_SW;
        mdr_load = mem_ack && op_q == OP_LW;
        nxt = !mem_ack ? (expired ? S_ERROR : S_MEM) : op_q == OP_LW ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel = op_q == OP_LW ? WB_MDR : WB_ALU;
        nxt = S_FETCH;
      end
      default: nxt = S_ERROR;
    endcase
  end
  // state, latched opcode, sticky error flags and retire counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= S_START;
      op_q <= OP_ALUR;
      halt_err <= 1'b0;
      bus_err <= 1'b0;
      instr_count <= '0;
    end else begin
      st <= nxt;
      if (st == S_DECODE) op_q <= opcode;
      halt_err <= halt_err | (st == S_DECODE && !is_legal(opcode));
      bus_err <= bus_err | (mem_phase && !mem_ack && expired);
      if (retire) instr_count <= instr_count + 32'd1;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized instruction streams checked cycle by cycle against a phase model
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic br_taken = 1'b0;
  logic mem_ack = 1'b0;
  logic mem_req, mem_sel, mem_we, ir_load, mdr_load, pc_load, alu_src, reg_write;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;
  logic halt_err, bus_err;
  logic [31:0] instr_count;
  int total = 0;
  int passed = 0;
  logic [31:0] cnt_m = 32'd0;
  logic halt_m = 1'b0;
  logic bus_m = 1'b0;
  logic [3:0] op_m = 4'd0;
  logic bt_m = 1'b0;
  logic [3:0] legal [8] = '{4'd0, 4'd8, 4'd2, 4'd10, 4'd9, 4'd5, 4'd6, 4'd11};

  cpu_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .br_taken(br_taken), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_load(ir_load), .mdr_load(mdr_load),
    .pc_load(pc_load), .pc_src(pc_src), .alu_src(alu_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .state(state), .halt_err(halt_err), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // expected strobes for a phase: 0 fetch, 1 decode, 2 exec, 3 mem, 4 wb, 5 start, 7 error
  function automatic logic [14:0] ev(input int ph, input logic a);
    logic [2:0] s;
    logic rq, sl, we, ir, md, pl, al, rw;
    logic [1:0] ps, wb;
    s = 3'(ph);
    {rq, sl, we, ir, md, pl, al, rw} = 8'b0;
    ps = 2'd0;
    wb = 2'd0;
    case (ph)
      0: begin rq = 1'b1; ir = a; pl = a; end
      2: begin
        al = !(op_m == 4'd0 || op_m == 4'd2);
        if (op_m == 4'd6) begin pl = bt_m; ps = 2'd1; end
        if (op_m == 4'd11) begin rw = 1'b1; wb = 2'd2; pl = 1'b1; ps = 2'd2; end
      end
      3: begin rq = 1'b1; sl = 1'b1; we = op_m == 4'd5; md = a && op_m == 4'd9; end
      4: begin rw = 1'b1; wb = op_m == 4'd9 ? 2'd1 : 2'd0; end
      default: ;
    endcase
    return {s, rq, sl, we, ir, md, pl, ps, al, rw, wb};
  endfunction

  function automatic logic [48:0] obs();
    return {state, mem_req, mem_sel, mem_we, ir_load, mdr_load, pc_load, pc_src, alu_src,
            reg_write, wb_sel, halt_err, bus_err, instr_count};
  endfunction

  task automatic chk(input string tag, input logic [48:0] o, input logic [48:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic step(input string tag, input int ph, input logic a);
    @(negedge clk);
    mem_ack = a;
    #1;
    chk(tag, obs(), {ev(ph, a), halt_m, bus_m, cnt_m});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    mem_ack = 1'b0;
    #1;
    cnt_m = 32'd0;
    halt_m = 1'b0;
    bus_m = 1'b0;
    chk(tag, obs(), {ev(5, 1'b0), 2'b00, 32'd0});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic begin_instr(input logic [3:0] op, input int fw, input logic bt);
    op_m = op;
    bt_m = bt;
    opcode = op;
    br_taken = bt;
    for (int i = 0; i <= fw; i++) step("fetch", 0, i == fw);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input int fw, input int mw, input logic bt);
    begin_instr(op, fw, bt);
    step(tag, 1, 1'($urandom));
    step(tag, 2, 1'($urandom));
    if (op == 4'd9 || op == 4'd5)
      for (int i = 0; i <= mw; i++) step(tag, 3, i == mw);
    if (op != 4'd6 && op != 4'd11 && op != 4'd5) step(tag, 4, 1'($urandom));
    cnt_m++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset_state");
    run("alur_zero_wait", 4'd0, 0, 0, 1'b0);
    run("lw_3_wait", 4'd9, 0, 3, 1'b0);
    run("branch_taken", 4'd6, 0, 0, 1'b1);
    run("branch_not_taken", 4'd6, 0, 0, 1'b0);
    run("jal", 4'd11, 0, 0, 1'b0);
    run("sw_ack_at_expiry", 4'd5, 4, 4, 1'b0);
    for (int n = 0; n < 40; n++)
      run("random", legal[$urandom_range(0, 7)], int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom));
    begin_instr(4'd4, 1, 1'b0);
    step("illegal_decode", 1, 1'b0);
    halt_m = 1'b1;
    for (int i = 0; i < 20; i++) step("illegal_hold", 7, 1'($urandom));
    do_reset("reset_after_halt");
    begin_instr(4'd5, 0, 1'b0);
    step("sw_decode", 1, 1'b0);
    step("sw_exec", 2, 1'b0);
    for (int i = 0; i <= 4; i++) step("sw_wait", 3, 1'b0);
    bus_m = 1'b1;
    for (int i = 0; i < 3; i++) step("bus_timeout", 7, 1'($urandom));
    do_reset("reset_after_bus");
    run("alur_recover", 4'd0, 1, 0, 1'b0);
    begin_instr(4'd5, 0, 1'b0);
    step("sw_decode2", 1, 1'b0);
    step("sw_exec2", 2, 1'b0);
    step("sw_wait1", 3, 1'b0);
    step("sw_wait2", 3, 1'b0);
    reset_n = 1'b0;
    #1;
    cnt_m = 32'd0;
    chk("async_reset_mid_mem", obs(), {ev(5, 1'b0), 2'b00, 32'd0});
    @(negedge clk);
    reset_n = 1'b1;
    run("alur_after_async", 4'd0, 0, 0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
